// File: rtl/components_pkg.sv
// components_pkg: shared debounce state encoding and time-to-cycles helper.
package components_pkg;

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} debounce_state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// synchronizer: multi-flop synchronizer bringing an async input into the clk domain.
module synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_sync <= {STAGES{RESET_LEVEL}};
    else      r_sync <= {r_sync[STAGES-2:0], d};

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes and debounces a raw input into a clean level with rise/fall strobes.
module input_debouncer
  import components_pkg::*;
#(
  parameter int   CLK_HZ        = 12_000_000,
  parameter int   DEBOUNCE_MS   = 10,
  parameter int   STABLE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int                CW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]     ONE       = CW'(1);
  localparam logic [CW-1:0]     LAST      = CW'(STABLE_CYCLES - 1);
  localparam bit                DIRECT    = STABLE_CYCLES == 1;
  localparam debounce_state_t   RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic            w_d_sync;
  debounce_state_t r_state;
  logic [CW-1:0]   r_count;
  logic            r_level, r_rise, r_fall, r_busy;

  synchronizer #(.STAGES(SYNC_STAGES), .RESET_LEVEL(RESET_LEVEL)) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (w_d_sync)
  );

  // The sample that enters a WAIT state already counts as the first stable cycle,
  // so the exit fires when the count reaches STABLE_CYCLES-1 before this edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= RST_STATE;
      r_count <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LO:
          if (w_d_sync) begin
            r_state <= DIRECT ? STABLE_HI : WAIT_HI;
            r_count <= DIRECT ? '0 : ONE;
            r_busy  <= !DIRECT;
            r_level <= DIRECT;
            r_rise  <= DIRECT;
          end
        WAIT_HI:
          if (!w_d_sync) begin
            r_state <= STABLE_LO;
            r_count <= '0;
            r_busy  <= 1'b0;
          end else if (r_count == LAST) begin
            r_state <= STABLE_HI;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else
            r_count <= r_count + ONE;
        STABLE_HI:
          if (!w_d_sync) begin
            r_state <= DIRECT ? STABLE_LO : WAIT_LO;
            r_count <= DIRECT ? '0 : ONE;
            r_busy  <= !DIRECT;
            r_level <= !DIRECT;
            r_fall  <= DIRECT;
          end
        WAIT_LO:
          if (w_d_sync) begin
            r_state <= STABLE_HI;
            r_count <= '0;
            r_busy  <= 1'b0;
          end else if (r_count == LAST) begin
            r_state <= STABLE_LO;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else
            r_count <= r_count + ONE;
        default: begin
          r_state <= r_level ? STABLE_HI : STABLE_LO;
          r_count <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign busy  = r_busy;

endmodule
